mem_stage: RTL and testbench

- Memory-access stage of the pipelined CPU, directly upstream of the write-back stage.
- Takes the execute result, drives a single-outstanding request/ready handshake to the external memory controller, and stalls upstream until the access completes.
- Holds the MEM/WB pipeline register (exeOut, MemOut, PCInc4, Rx, WbDataSel, WbRegSel, RegWrite) that write-back consumes.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/mem_stage_mem_wb_reg.sv | 32 +++
 rtl/mem_stage.sv | 172 +++++++++++++++++
 tb/tb_mem_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================
// Package : cpu_pkg
// Shared CPU types: MEM stage FSM states, write-back selects, MEM/WB bundle.
// Revision: 1.0
// ============================================================
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] REG_LR = 5'd31;

  localparam logic [1:0] WB_PC     = 2'b00;
  localparam logic [1:0] WB_PC_ALT = 2'b01;
  localparam logic [1:0] WB_MEM    = 2'b10;
  localparam logic [1:0] WB_EXE    = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] exe_out;
    logic [XLEN-1:0] mem_out;
    logic [XLEN-1:0] pc_inc4;
    logic [4:0]      rx;
    logic [1:0]      wb_data_sel;
    logic            wb_reg_sel;
    logic            reg_write;
  } mem_wb_t;

  localparam int MEM_WB_W = $bits(mem_wb_t);

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_mem_wb_reg.sv
`default_nettype none
// ============================================================
// Module : mem_wb_reg
// MEM/WB pipeline register: loads a new bundle or inserts a bubble.
// Revision: 1.0
// ============================================================
module mem_wb_reg
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [MEM_WB_W-1:0] d,
  output logic [MEM_WB_W-1:0] q,
  output logic                valid
);

  // Payload holds across bubbles; only the valid bit drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= load;
      if (load) begin
        q <= d;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================
// Module : mem_stage
// Memory-access stage: single-outstanding memory handshake, upstream stall, MEM/WB register.
// Revision: 1.0
// ============================================================
module mem_stage
  import cpu_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] exeOut_in,
  input  logic [N-1:0] storeData,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic [N-1:0] PCInc4_in,
  input  logic [4:0]   Rx_in,
  input  logic [1:0]   WbDataSel_in,
  input  logic         WbRegSel_in,
  input  logic         RegWrite_in,
  output logic         stall,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_rd,
  output logic         mem_wr,
  input  logic         mem_ready,
  input  logic [N-1:0] mem_rdata,
  output logic         mem_err,
  output logic         wb_valid,
  output logic [N-1:0] exeOut,
  output logic [N-1:0] MemOut,
  output logic [N-1:0] PCInc4,
  output logic [4:0]   Rx,
  output logic [1:0]   WbDataSel,
  output logic         WbRegSel,
  output logic         RegWrite
);

  if (N != XLEN) begin : g_width_check
    $error("mem_stage: N must match cpu_pkg::XLEN");
  end

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_check
    $error("mem_stage: TIMEOUT must be in 1..255");
  end

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_cnt;
  mem_wb_t       r_hold;
  logic          r_hold_is_load;

  logic          w_memop;
  logic          w_aligned;
  logic          w_issue;
  logic          w_misalign;
  logic          w_timeout;
  logic          w_abort;
  logic          w_wb_load;
  mem_wb_t       w_wb_d;
  logic [MEM_WB_W-1:0] w_wb_q_bits;
  mem_wb_t       w_wb_q;

  assign w_memop    = MemRead | MemWrite;
  assign w_aligned  = is_word_aligned(exeOut_in[1:0]);
  assign w_issue    = (r_state == IDLE) & in_valid & w_memop & w_aligned;
  assign w_misalign = (r_state == IDLE) & in_valid & w_memop & ~w_aligned;
  assign w_timeout  = (r_cnt == TIMEOUT_LAST);
  assign w_abort    = (r_state == BUSY) & ~mem_ready & w_timeout;

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    w_wb_load   = 1'b0;
    w_wb_d      = '0;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          stall       = 1'b1;
          w_state_nxt = BUSY;
        end else if (in_valid && !w_memop) begin
          w_wb_load          = 1'b1;
          w_wb_d.exe_out     = exeOut_in;
          w_wb_d.pc_inc4     = PCInc4_in;
          w_wb_d.rx          = Rx_in;
          w_wb_d.wb_data_sel = WbDataSel_in;
          w_wb_d.wb_reg_sel  = WbRegSel_in;
          w_wb_d.reg_write   = RegWrite_in;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          w_state_nxt    = IDLE;
          w_wb_load      = 1'b1;
          w_wb_d         = r_hold;
          w_wb_d.mem_out = r_hold_is_load ? mem_rdata : '0;
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= 8'd0;
      r_hold         <= '0;
      r_hold_is_load <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_rd         <= 1'b0;
      mem_wr         <= 1'b0;
      mem_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      mem_err <= w_misalign | w_abort;
      if (w_issue) begin
        mem_addr              <= exeOut_in;
        mem_wdata             <= storeData;
        mem_rd                <= MemRead;
        mem_wr                <= MemWrite & ~MemRead;
        r_cnt                 <= 8'd0;
        r_hold_is_load        <= MemRead;
        r_hold.exe_out        <= exeOut_in;
        r_hold.mem_out        <= '0;
        r_hold.pc_inc4        <= PCInc4_in;
        r_hold.rx             <= Rx_in;
        r_hold.wb_data_sel    <= WbDataSel_in;
        r_hold.wb_reg_sel     <= WbRegSel_in;
        // A pure store must never reach the register file.
        r_hold.reg_write      <= RegWrite_in & ~(MemWrite & ~MemRead);
      end else if (r_state == BUSY) begin
        if (mem_ready || w_timeout) begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (w_wb_load),
    .d     (w_wb_d),
    .q     (w_wb_q_bits),
    .valid (wb_valid)
  );

  assign w_wb_q    = mem_wb_t'(w_wb_q_bits);
  assign exeOut    = w_wb_q.exe_out;
  assign MemOut    = w_wb_q.mem_out;
  assign PCInc4    = w_wb_q.pc_inc4;
  assign Rx        = w_wb_q.rx;
  assign WbDataSel = w_wb_q.wb_data_sel;
  assign WbRegSel  = w_wb_q.wb_reg_sel;
  assign RegWrite  = w_wb_q.reg_write & wb_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// Bench for mem_stage: constant vector table, directed corner sequences and a
// randomized run checked against a transaction-level model of the stage.
module tb_mem_stage;
  import cpu_pkg::*;

  localparam int N  = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst, in_valid, MemRead, MemWrite, WbRegSel_in, RegWrite_in, mem_ready;
  logic [N-1:0] exeOut_in, storeData, PCInc4_in, mem_rdata;
  logic [4:0] Rx_in;
  logic [1:0] WbDataSel_in;
  logic stall, mem_rd, mem_wr, mem_err, wb_valid, WbRegSel, RegWrite;
  logic [N-1:0] mem_addr, mem_wdata, exeOut, MemOut, PCInc4;
  logic [4:0] Rx;
  logic [1:0] WbDataSel;

  always #5 clk = ~clk;

  mem_stage #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .exeOut_in(exeOut_in),
    .storeData(storeData), .MemRead(MemRead), .MemWrite(MemWrite),
    .PCInc4_in(PCInc4_in), .Rx_in(Rx_in), .WbDataSel_in(WbDataSel_in),
    .WbRegSel_in(WbRegSel_in), .RegWrite_in(RegWrite_in), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .wb_valid(wb_valid), .exeOut(exeOut), .MemOut(MemOut), .PCInc4(PCInc4),
    .Rx(Rx), .WbDataSel(WbDataSel), .WbRegSel(WbRegSel), .RegWrite(RegWrite)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Transaction-level model: one pending access plus the visible MEM/WB view.
  typedef struct {
    logic [31:0] exe, pc;
    logic [4:0]  rx;
    logic [1:0]  sel;
    logic        rsel, rw, is_load;
  } txn_t;

  bit          m_busy;
  int          m_wait;
  txn_t        m_pend;
  logic        e_rd, e_wr, e_err, e_wbv, e_rsel, e_rw;
  logic [31:0] e_addr, e_wdata, e_exe, e_mout, e_pc;
  logic [4:0]  e_rx;
  logic [1:0]  e_sel;

  task automatic model_reset();
    m_busy = 0; m_wait = 0;
    m_pend = '{exe: 0, pc: 0, rx: 0, sel: 0, rsel: 0, rw: 0, is_load: 0};
    {e_rd, e_wr, e_err, e_wbv, e_rsel, e_rw} = '0;
    {e_addr, e_wdata, e_exe, e_mout, e_pc} = '0;
    e_rx = '0; e_sel = '0;
  endtask

  function automatic logic model_stall();
    if (!m_busy)
      return in_valid && (MemRead || MemWrite) && (exeOut_in % 4 == 0);
    return !mem_ready && (m_wait != TO - 1);
  endfunction

  task automatic retire(input txn_t t, input logic [31:0] mout);
    e_wbv = 1; e_exe = t.exe; e_mout = mout; e_pc = t.pc;
    e_rx = t.rx; e_sel = t.sel; e_rsel = t.rsel; e_rw = t.rw;
  endtask

  task automatic model_step();
    txn_t t;
    if (rst) begin
      model_reset();
      return;
    end
    e_err = 0;
    e_wbv = 0;
    if (!m_busy) begin
      t = '{exe: exeOut_in, pc: PCInc4_in, rx: Rx_in, sel: WbDataSel_in,
            rsel: WbRegSel_in, rw: RegWrite_in, is_load: MemRead};
      if (in_valid && (MemRead || MemWrite)) begin
        if (exeOut_in % 4 != 0) begin
          e_err = 1;
        end else begin
          if (!MemRead) t.rw = 0;
          m_pend = t; m_busy = 1; m_wait = 0;
          e_addr = exeOut_in; e_wdata = storeData;
          e_rd = MemRead; e_wr = MemWrite && !MemRead;
        end
      end else if (in_valid) begin
        retire(t, 0);
      end
    end else if (mem_ready) begin
      retire(m_pend, m_pend.is_load ? mem_rdata : 32'h0);
      e_rd = 0; e_wr = 0; m_busy = 0;
    end else if (m_wait == TO - 1) begin
      e_rd = 0; e_wr = 0; e_err = 1; m_busy = 0;
    end else begin
      m_wait++;
    end
  endtask

  task automatic check_all();
    chk("mem_rd", 32'(mem_rd), 32'(e_rd));
    chk("mem_wr", 32'(mem_wr), 32'(e_wr));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("mem_err", 32'(mem_err), 32'(e_err));
    chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
    chk("exeOut", exeOut, e_exe);
    chk("MemOut", MemOut, e_mout);
    chk("PCInc4", PCInc4, e_pc);
    chk("Rx", 32'(Rx), 32'(e_rx));
    chk("WbDataSel", 32'(WbDataSel), 32'(e_sel));
    chk("WbRegSel", 32'(WbRegSel), 32'(e_rsel));
    chk("RegWrite", 32'(RegWrite), 32'(e_rw & e_wbv));
  endtask

  // Inputs are settled before the call; stall is checked, the edge taken, outputs checked.
  task automatic tick();
    #1;
    chk("stall", 32'(stall), 32'(model_stall()));
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_op(input logic v, input logic [31:0] a, input logic rd, input logic wr,
                        input logic [4:0] rx, input logic [1:0] sel, input logic rw);
    in_valid = v; exeOut_in = a; MemRead = rd; MemWrite = wr;
    Rx_in = rx; WbDataSel_in = sel; RegWrite_in = rw;
  endtask

  typedef struct {
    logic [31:0] exe, pc;
    logic [4:0]  rx;
    logic [1:0]  sel;
    logic        rsel, rw, exp_rw;
  } alu_vec_t;

  alu_vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_1234, 32'h0000_0040, 5'd3,   WB_EXE,    1'b0, 1'b1, 1'b1};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0044, REG_LR, WB_PC,     1'b1, 1'b1, 1'b1};
    vecs[2] = '{32'h0000_0000, 32'h0000_0048, 5'd0,   WB_EXE,    1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0001, 32'h0000_004C, 5'd17,  WB_PC_ALT, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{32'h0000_0003, 32'h0000_0050, 5'd30,  WB_MEM,    1'b1, 1'b1, 1'b1};

    rst = 1; mem_ready = 0; mem_rdata = 0; storeData = 0; PCInc4_in = 0; WbRegSel_in = 0;
    set_op(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    chk("reset_stall", 32'(stall), 32'h0);
    rst = 0;

    // ALU pass-through vectors
    for (int i = 0; i < 5; i++) begin
      set_op(1, vecs[i].exe, 0, 0, vecs[i].rx, vecs[i].sel, vecs[i].rw);
      PCInc4_in = vecs[i].pc; WbRegSel_in = vecs[i].rsel;
      tick();
      chk("alu_wbv", 32'(wb_valid), 32'h1);
      chk("alu_exe", exeOut, vecs[i].exe);
      chk("alu_pc", PCInc4, vecs[i].pc);
      chk("alu_rx", 32'(Rx), 32'(vecs[i].rx));
      chk("alu_sel", 32'(WbDataSel), 32'(vecs[i].sel));
      chk("alu_rw", 32'(RegWrite), 32'(vecs[i].exp_rw));
      chk("alu_mout", MemOut, 32'h0);
    end
    set_op(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("bubble_wbv", 32'(wb_valid), 32'h0);

    // Load with three-cycle latency
    set_op(1, 32'h100, 1, 0, 5'd5, WB_MEM, 1);
    tick();
    chk("ld_rd", 32'(mem_rd), 32'h1);
    chk("ld_addr", mem_addr, 32'h100);
    set_op(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ready = 0;
    chk("ld_mout", MemOut, 32'hDEADBEEF);
    chk("ld_wbv", 32'(wb_valid), 32'h1);
    chk("ld_rd_off", 32'(mem_rd), 32'h0);
    chk("ld_rw", 32'(RegWrite), 32'h1);

    // Store, ready on first busy cycle
    set_op(1, 32'h200, 0, 1, 5'd7, WB_EXE, 1);
    storeData = 32'hA5A5A5A5;
    tick();
    chk("st_wr", 32'(mem_wr), 32'h1);
    chk("st_wdata", mem_wdata, 32'hA5A5A5A5);
    set_op(0, 0, 0, 0, 0, 0, 0);
    mem_ready = 1;
    tick();
    mem_ready = 0;
    chk("st_wr_off", 32'(mem_wr), 32'h0);
    chk("st_wbv", 32'(wb_valid), 32'h1);
    chk("st_rw", 32'(RegWrite), 32'h0);

    // Timeout abort
    set_op(1, 32'h300, 1, 0, 5'd9, WB_MEM, 1);
    tick();
    set_op(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("to_err_early", 32'(mem_err), 32'h0);
    chk("to_rd_held", 32'(mem_rd), 32'h1);
    tick();
    chk("to_err", 32'(mem_err), 32'h1);
    chk("to_rd_off", 32'(mem_rd), 32'h0);
    chk("to_wbv", 32'(wb_valid), 32'h0);
    tick();
    chk("to_err_pulse", 32'(mem_err), 32'h0);

    // Misaligned load
    set_op(1, 32'h102, 1, 0, 5'd4, WB_MEM, 1);
    tick();
    set_op(0, 0, 0, 0, 0, 0, 0);
    chk("mis_rd", 32'(mem_rd), 32'h0);
    chk("mis_err", 32'(mem_err), 32'h1);
    chk("mis_wbv", 32'(wb_valid), 32'h0);
    tick();
    chk("mis_err_pulse", 32'(mem_err), 32'h0);

    // Reset while busy, then a stray ready
    set_op(1, 32'h400, 1, 0, 5'd6, WB_MEM, 1);
    tick();
    set_op(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1;
    tick();
    rst = 0;
    mem_ready = 1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ready = 0;
    chk("rb_wbv", 32'(wb_valid), 32'h0);
    chk("rb_rd", 32'(mem_rd), 32'h0);
    chk("rb_addr", mem_addr, 32'h0);
    chk("rb_exe", exeOut, 32'h0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      rst = ($urandom_range(63) == 0);
      set_op($urandom_range(1), a, $urandom_range(1), $urandom_range(1),
             5'($urandom), 2'($urandom), $urandom_range(1));
      storeData = $urandom; PCInc4_in = $urandom; WbRegSel_in = $urandom_range(1);
      mem_ready = ($urandom_range(2) == 0);
      mem_rdata = $urandom;
      tick();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
